// File: rtl/i2s_dma_pkg.sv
// ============================================================================
// i2s_dma_pkg : state encodings and default sizes shared by the I2S DMA controllers
// Revision 1.0
// ============================================================================
`default_nettype none

package i2s_dma_pkg;

   localparam int DMA_CNT_W      = 9;
   localparam int DMA_LVL_W      = 10;
   localparam int DMA_FIFO_DEPTH = 512;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_REQ   = 3'd2,
      ST_XFR   = 3'd3,
      ST_DONE  = 3'd4
   } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/i2s_dma_sync2ff.sv
// ============================================================================
// i2s_dma_sync2ff : two-flop synchronizer, cleared by reset or by the I2S enable dropping
// Revision 1.0
// ============================================================================
`default_nettype none

module i2s_dma_sync2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/i2s_slave_tx_dma_sm.sv
// ============================================================================
// i2s_slave_tx_dma_sm : TX FIFO DMA request/burst controller with underrun flag
// Revision 1.0
// ============================================================================
`default_nettype none

module i2s_slave_tx_dma_sm
   import i2s_dma_pkg::*;
#(
   parameter int CNT_W      = DMA_CNT_W,
   parameter int LVL_W      = DMA_LVL_W,
   parameter int FIFO_DEPTH = DMA_FIFO_DEPTH
) (
   input  logic             WBs_CLK_i,
   input  logic             WBs_RST_i,
   input  logic             I2S_S_EN_i,
   input  logic             DMA_Start_i,
   input  logic [CNT_W-1:0] DMA_CNT_i,
   input  logic [LVL_W-1:0] TXFIFO_Level_i,
   input  logic             TXFIFO_Push_i,
   input  logic             TXFIFO_Pop_i,
   input  logic             TXFIFO_Empty_i,
   input  logic             Underrun_Clr_i,
   input  logic             DMA_Active_i,
   output logic             DMA_REQ_o,
   output logic             DMA_DONE_o,
   output logic             DMA_Clr_o,
   output logic             DMA_Active_o,
   output logic             DMA_Busy_o,
   output logic             Underrun_o,
   output logic [CNT_W-1:0] dma_cntr_o,
   output logic [2:0]       dma_st_o
);

   localparam int SUM_W = ((LVL_W > CNT_W) ? LVL_W : CNT_W) + 1;
   localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);

   dma_state_e       state_q, state_d;
   logic [CNT_W-1:0] cntr_q, cntr_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             req_q, busy_q, done_q, clr_q, underrun_q;
   logic             req_d, busy_d, done_d, clr_d;
   logic             sync_clr;
   logic             space_ok;

   assign sync_clr = WBs_RST_i || !I2S_S_EN_i;

   // Compare level+len against depth so an over-reported level never wraps into "space available".
   assign space_ok = (SUM_W'(TXFIFO_Level_i) + SUM_W'(len_q)) <= DEPTH_S;

   i2s_dma_sync2ff u_active_sync (
      .clk_i (WBs_CLK_i),
      .rst_i (WBs_RST_i),
      .en_i  (I2S_S_EN_i),
      .d_i   (DMA_Active_i),
      .q_o   (DMA_Active_o)
   );

   always_comb begin
      state_d = state_q;
      cntr_d  = cntr_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: begin
            cntr_d = '0;
            if (DMA_Start_i) begin
               state_d = ST_WAIT;
               len_d   = DMA_CNT_i;
            end
         end
         ST_WAIT: begin
            if (!DMA_Start_i)  state_d = ST_IDLE;
            else if (space_ok) state_d = ST_REQ;
         end
         ST_REQ: begin
            // Once SDMA has acknowledged, follow it into XFR even if Start just dropped.
            if (DMA_Active_o)      state_d = ST_XFR;
            else if (!DMA_Start_i) state_d = ST_IDLE;
         end
         ST_XFR: begin
            if (cntr_q == len_q)    state_d = ST_DONE;
            else if (TXFIFO_Push_i) cntr_d  = cntr_q + CNT_W'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_d  = (state_d == ST_REQ);
      busy_d = (state_d == ST_WAIT) || (state_d == ST_REQ) || (state_d == ST_XFR);
      done_d = (state_d == ST_DONE);
      clr_d  = (state_q == ST_REQ) && (state_d == ST_XFR);
   end

   always_ff @(posedge WBs_CLK_i) begin
      if (sync_clr) begin
         state_q <= ST_IDLE;
         cntr_q  <= '0;
         len_q   <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cntr_q  <= cntr_d;
         len_q   <= len_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
      end
   end

   // Underrun survives an I2S disable so software can still read why the stream stopped.
   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i)                          underrun_q <= 1'b0;
      else if (TXFIFO_Pop_i && TXFIFO_Empty_i) underrun_q <= 1'b1;
      else if (Underrun_Clr_i)                underrun_q <= 1'b0;
   end

   assign DMA_REQ_o  = req_q;
   assign DMA_DONE_o = done_q;
   assign DMA_Clr_o  = clr_q;
   assign DMA_Busy_o = busy_q;
   assign Underrun_o = underrun_q;
   assign dma_cntr_o = cntr_q;
   assign dma_st_o   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_slave_tx_dma_sm.sv
// ============================================================================
// tb_i2s_slave_tx_dma_sm : scenario tasks with a scoreboard of expected burst counts
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_i2s_slave_tx_dma_sm;

   logic       clk = 1'b0;
   logic       rst, en, start, push, pop, empty, uclr, active;
   logic [8:0] cnt;
   logic [9:0] lvl;
   logic       req_o, done_o, clr_o, act_o, busy_o, und_o;
   logic [8:0] cntr_o;
   logic [2:0] st_o;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   i2s_slave_tx_dma_sm dut (
      .WBs_CLK_i      (clk),
      .WBs_RST_i      (rst),
      .I2S_S_EN_i     (en),
      .DMA_Start_i    (start),
      .DMA_CNT_i      (cnt),
      .TXFIFO_Level_i (lvl),
      .TXFIFO_Push_i  (push),
      .TXFIFO_Pop_i   (pop),
      .TXFIFO_Empty_i (empty),
      .Underrun_Clr_i (uclr),
      .DMA_Active_i   (active),
      .DMA_REQ_o      (req_o),
      .DMA_DONE_o     (done_o),
      .DMA_Clr_o      (clr_o),
      .DMA_Active_o   (act_o),
      .DMA_Busy_o     (busy_o),
      .Underrun_o     (und_o),
      .dma_cntr_o     (cntr_o),
      .dma_st_o       (st_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to_xfr(input logic [9:0] level, input logic [8:0] len);
      bit ok = 0;
      lvl = level; cnt = len; start = 1'b1; active = 1'b1;
      for (int i = 0; i < 12 && !ok; i++) begin
         tick();
         if (st_o == 3'd3) ok = 1;
      end
      active = 1'b0;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL reach_xfr: state %0d, required 3", st_o); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_tests++;
      if ({req_o, done_o, clr_o, act_o, busy_o, und_o, cntr_o, st_o} !== 18'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: req%b done%b clr%b act%b busy%b und%b cntr%0d st%0d, required all 0",
                  req_o, done_o, clr_o, act_o, busy_o, und_o, cntr_o, st_o);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (st_o !== 3'd0) begin n_fail++; $display("FAIL idle_no_start: state %0d, required 0", st_o); end
   endtask

   task automatic test_basic_burst();
      int n_req = 0, n_clr = 0, n_done = 0, act_lat = -1, xfr_at = -1;
      bit seen = 0;
      lvl = 10'd100; cnt = 9'd64; start = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (req_o) seen = 1;
      end
      n_tests++;
      if (!seen || st_o !== 3'd2 || !busy_o) begin
         n_fail++; $display("FAIL req_rise: req %b st %0d busy %b, required 1/2/1", req_o, st_o, busy_o);
      end
      n_req = 1;
      for (int i = 0; i < 2; i++) begin tick(); if (req_o) n_req++; end
      active = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (req_o) n_req++;
         if (clr_o) n_clr++;
         if (act_o && act_lat < 0) act_lat = i;
         if (st_o == 3'd3) begin xfr_at = i; break; end
      end
      active = 1'b0;
      n_tests++;
      if (act_lat !== 2) begin n_fail++; $display("FAIL active_sync_latency: %0d, required 2", act_lat); end
      n_tests++;
      if (xfr_at !== 3) begin n_fail++; $display("FAIL xfr_entry: cycle %0d, required 3", xfr_at); end
      n_tests++;
      if (n_req !== 5) begin n_fail++; $display("FAIL req_cycles: %0d, required 5", n_req); end
      exp_q.push_back(64);
      push = 1'b1;
      for (int i = 0; i < 64; i++) begin tick(); if (clr_o) n_clr++; end
      push = 1'b0;
      n_tests++;
      if (n_clr !== 1) begin n_fail++; $display("FAIL clr_pulse: %0d pulses, required 1", n_clr); end
      for (int i = 0; i < 6 && n_done == 0; i++) begin
         tick();
         if (done_o) begin
            n_done++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL sb_underflow: done with cntr %0d, nothing expected", cntr_o);
            end else begin
               int e = exp_q.pop_front();
               if (int'(cntr_o) !== e) begin n_fail++; $display("FAIL burst_cntr: %0d, required %0d", cntr_o, e); end
            end
            n_tests++;
            if (busy_o !== 1'b0 || st_o !== 3'd4) begin
               n_fail++; $display("FAIL done_state: busy %b st %0d, required 0/4", busy_o, st_o);
            end
         end
      end
      tick();
      if (done_o) n_done++;
      n_tests++;
      if (st_o !== 3'd0) begin n_fail++; $display("FAIL after_done_idle: st %0d, required 0", st_o); end
      tick();
      if (done_o) n_done++;
      n_tests++;
      if (st_o !== 3'd1 || busy_o !== 1'b1) begin
         n_fail++; $display("FAIL rearm: st %0d busy %b, required 1/1", st_o, busy_o);
      end
      start = 1'b0;
      tick();
      if (done_o) n_done++;
      n_tests++;
      if (st_o !== 3'd0 || n_done !== 1) begin
         n_fail++; $display("FAIL wait_abort: st %0d dones %0d, required 0/1", st_o, n_done);
      end
   endtask

   task automatic test_space_and_abort();
      int bad = 0, n_done = 0;
      lvl = 10'd480; cnt = 9'd64; start = 1'b1;
      for (int i = 0; i < 6; i++) begin tick(); if (req_o) bad++; end
      n_tests++;
      if (bad !== 0 || st_o !== 3'd1) begin
         n_fail++; $display("FAIL no_space_hold: req cycles %0d st %0d, required 0/1", bad, st_o);
      end
      lvl = 10'd448;
      tick();
      n_tests++;
      if (req_o !== 1'b1 || st_o !== 3'd2) begin
         n_fail++; $display("FAIL exact_space_req: req %b st %0d, required 1/2", req_o, st_o);
      end
      start = 1'b0;
      tick();
      n_tests++;
      if (st_o !== 3'd0 || req_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL req_abort: st %0d req %b busy %b, required 0/0/0", st_o, req_o, busy_o);
      end
      for (int i = 0; i < 4; i++) begin tick(); if (done_o) n_done++; end
      n_tests++;
      if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: %0d pulses, required 0", n_done); end
      lvl = 10'd0;
   endtask

   task automatic test_zero_len();
      exp_q.push_back(0);
      run_to_xfr(10'd0, 9'd0);
      start = 1'b0;
      tick();
      n_tests++;
      if (st_o !== 3'd4 || done_o !== 1'b1) begin
         n_fail++; $display("FAIL zero_len_done: st %0d done %b, required 4/1", st_o, done_o);
      end
      if (done_o) begin
         int e = exp_q.pop_front();
         n_tests++;
         if (int'(cntr_o) !== e) begin n_fail++; $display("FAIL zero_len_cntr: %0d, required %0d", cntr_o, e); end
      end
      tick();
      n_tests++;
      if (st_o !== 3'd0) begin n_fail++; $display("FAIL zero_len_idle: st %0d, required 0", st_o); end
   endtask

   task automatic test_saturate();
      int max_c = 0, n_done = 0;
      exp_q.push_back(64);
      run_to_xfr(10'd0, 9'd64);
      start = 1'b0;
      push  = 1'b1;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (int'(cntr_o) > max_c) max_c = int'(cntr_o);
         if (i == 10) begin
            n_tests++;
            if (st_o !== 3'd3) begin n_fail++; $display("FAIL xfr_ignores_start: st %0d, required 3", st_o); end
         end
         if (done_o) begin
            n_done++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL sb_underflow: done with cntr %0d, nothing expected", cntr_o);
            end else begin
               int e = exp_q.pop_front();
               if (int'(cntr_o) !== e) begin n_fail++; $display("FAIL sat_cntr: %0d, required %0d", cntr_o, e); end
            end
         end
      end
      push = 1'b0;
      n_tests++;
      if (max_c !== 64 || n_done !== 1) begin
         n_fail++; $display("FAIL saturate: max %0d dones %0d, required 64/1", max_c, n_done);
      end
      n_tests++;
      if (cntr_o !== 9'd0) begin n_fail++; $display("FAIL idle_clears_cntr: %0d, required 0", cntr_o); end
   endtask

   task automatic test_reset_mid_xfr();
      run_to_xfr(10'd0, 9'd20);
      push = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      push = 1'b0; pop = 1'b1; empty = 1'b1;
      tick();
      pop = 1'b0; empty = 1'b0; start = 1'b0;
      n_tests++;
      if (cntr_o !== 9'd5 || st_o !== 3'd3 || und_o !== 1'b1) begin
         n_fail++; $display("FAIL mid_xfr: cntr %0d st %0d und %b, required 5/3/1", cntr_o, st_o, und_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({req_o, done_o, clr_o, act_o, busy_o, und_o, cntr_o, st_o} !== 18'd0) begin
         n_fail++;
         $display("FAIL reset_mid_xfr: req%b done%b clr%b act%b busy%b und%b cntr%0d st%0d, required all 0",
                  req_o, done_o, clr_o, act_o, busy_o, und_o, cntr_o, st_o);
      end
      run_to_xfr(10'd0, 9'd20);
      pop = 1'b1; empty = 1'b1;
      tick();
      pop = 1'b0; empty = 1'b0; en = 1'b0; start = 1'b0;
      tick();
      n_tests++;
      if (st_o !== 3'd0 || busy_o !== 1'b0 || und_o !== 1'b1) begin
         n_fail++; $display("FAIL en_clear: st %0d busy %b und %b, required 0/0/1", st_o, busy_o, und_o);
      end
      en = 1'b1; uclr = 1'b1;
      tick();
      uclr = 1'b0;
   endtask

   task automatic test_underrun();
      pop = 1'b1; empty = 1'b0;
      tick();
      n_tests++;
      if (und_o !== 1'b0) begin n_fail++; $display("FAIL pop_not_empty: und %b, required 0", und_o); end
      empty = 1'b1; uclr = 1'b1;
      tick();
      n_tests++;
      if (und_o !== 1'b1) begin n_fail++; $display("FAIL set_wins: und %b, required 1", und_o); end
      pop = 1'b0; empty = 1'b0;
      tick();
      uclr = 1'b0;
      n_tests++;
      if (und_o !== 1'b0) begin n_fail++; $display("FAIL underrun_clr: und %b, required 0", und_o); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; start = 1'b0; push = 1'b0; pop = 1'b0; empty = 1'b0;
      uclr = 1'b0; active = 1'b0; cnt = '0; lvl = '0;
      test_reset();
      test_basic_burst();
      test_space_and_abort();
      test_zero_len();
      test_saturate();
      test_reset_mid_xfr();
      test_underrun();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: %0d bursts never completed, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
